// File: rtl/alu_rs_pkg.sv
// rtl/alu_rs_pkg.sv - shared widths, tag encoding and ALU opcodes for the ALU reservation station
package alu_rs_pkg;

    localparam int DATA_WIDTH      = 32;
    localparam int ROB_ENTRY_WIDTH = 4;
    localparam int REG_LOCK_WIDTH  = ROB_ENTRY_WIDTH + 1;
    localparam int ALU_OP_WIDTH    = 5;

    // Top tag bit set means "no pending producer"; ROB tags occupy the low half.
    localparam logic [REG_LOCK_WIDTH-1:0] REG_NO_LOCK = {1'b1, {ROB_ENTRY_WIDTH{1'b0}}};

    typedef enum logic [ALU_OP_WIDTH-1:0] {
        ALU_ADD  = 5'd0,
        ALU_SUB  = 5'd1,
        ALU_AND  = 5'd2,
        ALU_OR   = 5'd3,
        ALU_XOR  = 5'd4,
        ALU_SLL  = 5'd5,
        ALU_SRL  = 5'd6,
        ALU_SRA  = 5'd7,
        ALU_SLT  = 5'd8,
        ALU_SLTU = 5'd9
    } alu_op_e;

    function automatic logic cdb_hit(input logic [REG_LOCK_WIDTH-1:0] q,
                                     input logic [REG_LOCK_WIDTH-1:0] cdb);
        return (cdb != REG_NO_LOCK) && (q == cdb);
    endfunction

endpackage

// File: rtl/alu_rs_select.sv
// rtl/alu_rs_select.sv - picks the ready entry with the smallest age as a one-hot grant
module rs_select #(
    parameter int ENTRIES = 4,
    parameter int AGE_W   = 2
) (
    input  logic [ENTRIES-1:0]       ready_i,
    input  logic [ENTRIES*AGE_W-1:0] ages_i,
    output logic [ENTRIES-1:0]       grant_o,
    output logic                     any_o
);

    logic             found;
    logic [AGE_W-1:0] best_age;

    always_comb begin
        grant_o  = '0;
        found    = 1'b0;
        best_age = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (ready_i[i] && (!found || (ages_i[i*AGE_W +: AGE_W] < best_age))) begin
                grant_o    = '0;
                grant_o[i] = 1'b1;
                best_age   = ages_i[i*AGE_W +: AGE_W];
                found      = 1'b1;
            end
        end
    end

    assign any_o = found;

endmodule

// File: rtl/alu_rs.sv
// rtl/alu_rs.sv - ALU reservation station: tag capture from the CDB and oldest-ready issue
module alu_rs
    import alu_rs_pkg::*;
#(
    parameter int ENTRIES = 4,
    parameter int DATA_W  = DATA_WIDTH,
    parameter int TAG_W   = REG_LOCK_WIDTH,
    parameter int OP_W    = ALU_OP_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              dec_valid,
    input  logic [OP_W-1:0]   dec_op,
    input  logic [TAG_W-1:0]  dec_tag_a,
    input  logic [TAG_W-1:0]  dec_tag_b,
    input  logic [DATA_W-1:0] dec_val_a,
    input  logic [DATA_W-1:0] dec_val_b,
    input  logic [TAG_W-1:0]  dec_dest,
    output logic              rs_full,
    input  logic [TAG_W-1:0]  cdb_index,
    input  logic [DATA_W-1:0] cdb_result,
    output logic              alu_valid,
    input  logic              alu_ready,
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [TAG_W-1:0]  alu_dest
);

    localparam int AGE_W = $clog2(ENTRIES);
    localparam logic [TAG_W-1:0] NO_LOCK = REG_NO_LOCK;

    logic [ENTRIES-1:0] busy_q, busy_d;
    logic [OP_W-1:0]    op_q   [ENTRIES];
    logic [OP_W-1:0]    op_d   [ENTRIES];
    logic [TAG_W-1:0]   qa_q   [ENTRIES];
    logic [TAG_W-1:0]   qa_d   [ENTRIES];
    logic [TAG_W-1:0]   qb_q   [ENTRIES];
    logic [TAG_W-1:0]   qb_d   [ENTRIES];
    logic [DATA_W-1:0]  va_q   [ENTRIES];
    logic [DATA_W-1:0]  va_d   [ENTRIES];
    logic [DATA_W-1:0]  vb_q   [ENTRIES];
    logic [DATA_W-1:0]  vb_d   [ENTRIES];
    logic [TAG_W-1:0]   dest_q [ENTRIES];
    logic [TAG_W-1:0]   dest_d [ENTRIES];
    logic [AGE_W-1:0]   age_q  [ENTRIES];
    logic [AGE_W-1:0]   age_d  [ENTRIES];

    logic              alu_valid_q, alu_valid_d;
    logic [OP_W-1:0]   alu_op_q,    alu_op_d;
    logic [DATA_W-1:0] alu_a_q,     alu_a_d;
    logic [DATA_W-1:0] alu_b_q,     alu_b_d;
    logic [TAG_W-1:0]  alu_dest_q,  alu_dest_d;

    logic [ENTRIES-1:0]       ready;
    logic [ENTRIES*AGE_W-1:0] ages_flat;
    logic [ENTRIES-1:0]       grant;
    logic                     any_ready;
    logic [AGE_W-1:0]         sel_idx;
    logic [AGE_W-1:0]         free_idx;
    logic [AGE_W:0]           busy_cnt;
    logic [AGE_W-1:0]         new_age;
    logic                     issue;
    logic                     alloc;
    logic                     hit_a;
    logic                     hit_b;

    // Readiness looks only at registered tags, so a broadcast never issues in its own cycle.
    always_comb begin
        ready     = '0;
        ages_flat = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            ready[i] = busy_q[i] && (qa_q[i] == NO_LOCK) && (qb_q[i] == NO_LOCK);
            ages_flat[i*AGE_W +: AGE_W] = age_q[i];
        end
    end

    rs_select #(
        .ENTRIES (ENTRIES),
        .AGE_W   (AGE_W)
    ) u_select (
        .ready_i (ready),
        .ages_i  (ages_flat),
        .grant_o (grant),
        .any_o   (any_ready)
    );

    always_comb begin
        sel_idx  = '0;
        free_idx = '0;
        busy_cnt = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (grant[i]) sel_idx = AGE_W'(i);
            if (busy_q[i]) busy_cnt = busy_cnt + (AGE_W+1)'(1);
        end
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!busy_q[i]) free_idx = AGE_W'(i);
        end
    end

    assign rs_full = &busy_q;
    assign issue   = any_ready && (!alu_valid_q || alu_ready);
    assign alloc   = dec_valid && !rs_full;
    assign new_age = AGE_W'(busy_cnt - (AGE_W+1)'(issue));
    assign hit_a   = cdb_hit(dec_tag_a, cdb_index);
    assign hit_b   = cdb_hit(dec_tag_b, cdb_index);

    always_comb begin
        busy_d      = busy_q;
        op_d        = op_q;
        qa_d        = qa_q;
        qb_d        = qb_q;
        va_d        = va_q;
        vb_d        = vb_q;
        dest_d      = dest_q;
        age_d       = age_q;
        alu_valid_d = alu_valid_q;
        alu_op_d    = alu_op_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_dest_d  = alu_dest_q;

        for (int i = 0; i < ENTRIES; i++) begin
            if (busy_q[i] && cdb_hit(qa_q[i], cdb_index)) begin
                qa_d[i] = NO_LOCK;
                va_d[i] = cdb_result;
            end
            if (busy_q[i] && cdb_hit(qb_q[i], cdb_index)) begin
                qb_d[i] = NO_LOCK;
                vb_d[i] = cdb_result;
            end
        end

        if (issue) begin
            alu_valid_d     = 1'b1;
            alu_op_d        = op_q[sel_idx];
            alu_a_d         = va_q[sel_idx];
            alu_b_d         = vb_q[sel_idx];
            alu_dest_d      = dest_q[sel_idx];
            busy_d[sel_idx] = 1'b0;
            // Close the gap left by the issued entry so ages stay dense from zero.
            for (int i = 0; i < ENTRIES; i++) begin
                if (busy_q[i] && (age_q[i] > age_q[sel_idx])) begin
                    age_d[i] = age_q[i] - AGE_W'(1);
                end
            end
        end else if (alu_ready) begin
            alu_valid_d = 1'b0;
        end

        if (alloc) begin
            busy_d[free_idx] = 1'b1;
            op_d[free_idx]   = dec_op;
            qa_d[free_idx]   = hit_a ? NO_LOCK : dec_tag_a;
            va_d[free_idx]   = hit_a ? cdb_result : dec_val_a;
            qb_d[free_idx]   = hit_b ? NO_LOCK : dec_tag_b;
            vb_d[free_idx]   = hit_b ? cdb_result : dec_val_b;
            dest_d[free_idx] = dec_dest;
            age_d[free_idx]  = new_age;
        end

        if (flush) begin
            busy_d      = '0;
            alu_valid_d = 1'b0;
            for (int i = 0; i < ENTRIES; i++) age_d[i] = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q      <= '0;
            alu_valid_q <= 1'b0;
            alu_op_q    <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_dest_q  <= NO_LOCK;
            for (int i = 0; i < ENTRIES; i++) begin
                op_q[i]   <= '0;
                qa_q[i]   <= NO_LOCK;
                qb_q[i]   <= NO_LOCK;
                va_q[i]   <= '0;
                vb_q[i]   <= '0;
                dest_q[i] <= NO_LOCK;
                age_q[i]  <= '0;
            end
        end else begin
            busy_q      <= busy_d;
            op_q        <= op_d;
            qa_q        <= qa_d;
            qb_q        <= qb_d;
            va_q        <= va_d;
            vb_q        <= vb_d;
            dest_q      <= dest_d;
            age_q       <= age_d;
            alu_valid_q <= alu_valid_d;
            alu_op_q    <= alu_op_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_dest_q  <= alu_dest_d;
        end
    end

    assign alu_valid = alu_valid_q;
    assign alu_op    = alu_op_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_dest  = alu_dest_q;

endmodule

// File: tb/tb_alu_rs.sv
// tb/tb_alu_rs.sv - directed bench for alu_rs with an in-order queue model of the station
module tb_alu_rs;
    import alu_rs_pkg::*;

    localparam int ENTRIES = 4;
    localparam int DW = DATA_WIDTH;
    localparam int TW = REG_LOCK_WIDTH;
    localparam int OW = ALU_OP_WIDTH;
    localparam logic [TW-1:0] NL = REG_NO_LOCK;

    logic          clk, rst, flush, dec_valid, rs_full, alu_valid, alu_ready;
    logic [OW-1:0] dec_op, alu_op;
    logic [TW-1:0] dec_tag_a, dec_tag_b, dec_dest, cdb_index, alu_dest;
    logic [DW-1:0] dec_val_a, dec_val_b, cdb_result, alu_a, alu_b;

    alu_rs #(.ENTRIES(ENTRIES), .DATA_W(DW), .TAG_W(TW), .OP_W(OW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .dec_valid(dec_valid), .dec_op(dec_op),
        .dec_tag_a(dec_tag_a), .dec_tag_b(dec_tag_b),
        .dec_val_a(dec_val_a), .dec_val_b(dec_val_b),
        .dec_dest(dec_dest), .rs_full(rs_full),
        .cdb_index(cdb_index), .cdb_result(cdb_result),
        .alu_valid(alu_valid), .alu_ready(alu_ready),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_dest(alu_dest)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: entries kept in allocation order, so the oldest ready one is the first ready one.
    typedef struct {
        logic [OW-1:0] op;
        logic [TW-1:0] qa, qb, dest;
        logic [DW-1:0] va, vb;
    } ent_t;

    ent_t          mq[$];
    logic          exp_valid = 1'b0;
    logic [OW-1:0] exp_op;
    logic [DW-1:0] exp_a, exp_b;
    logic [TW-1:0] exp_dest;

    always @(posedge clk or posedge rst) begin
        int   pick;
        int   old_size;
        ent_t e;
        if (rst) begin
            mq.delete();
            exp_valid = 1'b0;
        end else begin
            pick     = -1;
            old_size = mq.size();
            if (!exp_valid || alu_ready) begin
                for (int i = 0; i < mq.size(); i++)
                    if (pick < 0 && mq[i].qa == NL && mq[i].qb == NL) pick = i;
            end
            if (flush) begin
                mq.delete();
                exp_valid = 1'b0;
            end else begin
                if (pick >= 0) begin
                    exp_valid = 1'b1;
                    exp_op    = mq[pick].op;
                    exp_a     = mq[pick].va;
                    exp_b     = mq[pick].vb;
                    exp_dest  = mq[pick].dest;
                end else if (alu_ready) begin
                    exp_valid = 1'b0;
                end
                if (cdb_index != NL) begin
                    for (int i = 0; i < mq.size(); i++) begin
                        if (mq[i].qa == cdb_index) begin mq[i].qa = NL; mq[i].va = cdb_result; end
                        if (mq[i].qb == cdb_index) begin mq[i].qb = NL; mq[i].vb = cdb_result; end
                    end
                end
                if (pick >= 0) mq.delete(pick);
                if (dec_valid && old_size < ENTRIES) begin
                    e.op   = dec_op;
                    e.dest = dec_dest;
                    e.qa   = (dec_tag_a == cdb_index) ? NL : dec_tag_a;
                    e.va   = (dec_tag_a == cdb_index && cdb_index != NL) ? cdb_result : dec_val_a;
                    e.qb   = (dec_tag_b == cdb_index) ? NL : dec_tag_b;
                    e.vb   = (dec_tag_b == cdb_index && cdb_index != NL) ? cdb_result : dec_val_b;
                    mq.push_back(e);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("cmp_valid", alu_valid, exp_valid);
            check("cmp_full", rs_full, mq.size() == ENTRIES);
            if (exp_valid) begin
                check("cmp_op", alu_op, exp_op);
                check("cmp_a", alu_a, exp_a);
                check("cmp_b", alu_b, exp_b);
                check("cmp_dest", alu_dest, exp_dest);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_alloc(input logic [OW-1:0] op, input logic [TW-1:0] ta, input logic [DW-1:0] va,
                             input logic [TW-1:0] tb, input logic [DW-1:0] vb, input logic [TW-1:0] dest);
        dec_valid = 1'b1;
        dec_op    = op;
        dec_tag_a = ta;
        dec_val_a = va;
        dec_tag_b = tb;
        dec_val_b = vb;
        dec_dest  = dest;
    endtask

    initial begin
        clk = 0; rst = 0; flush = 0; dec_valid = 0; dec_op = '0;
        dec_tag_a = NL; dec_tag_b = NL; dec_val_a = '0; dec_val_b = '0; dec_dest = '0;
        cdb_index = NL; cdb_result = '0; alu_ready = 1;
        #1 rst = 1;
        #1;
        check("rst_valid", alu_valid, 0);
        check("rst_full", rs_full, 0);
        check("rst_op", alu_op, 0);
        check("rst_a", alu_a, 0);
        check("rst_b", alu_b, 0);
        check("rst_dest", alu_dest, NL);
        tick(); tick();
        rst = 0;
        tick();

        // Ready operands: two-edge latency
        set_alloc(ALU_ADD, NL, 5, NL, 7, 3);
        tick(); dec_valid = 0;
        check("t1_lat", alu_valid, 0);
        tick();
        check("t1_valid", alu_valid, 1);
        check("t1_op", alu_op, ALU_ADD);
        check("t1_a", alu_a, 5);
        check("t1_b", alu_b, 7);
        check("t1_dest", alu_dest, 3);
        tick();
        check("t1_drain", alu_valid, 0);

        // Operand A waits on tag 2
        set_alloc(ALU_SUB, 2, 0, NL, 1, 4);
        tick(); dec_valid = 0;
        tick(); tick();
        check("t2_wait", alu_valid, 0);
        cdb_index = 2; cdb_result = 32'h1234;
        tick(); cdb_index = NL;
        check("t2_cap", alu_valid, 0);
        tick();
        check("t2_valid", alu_valid, 1);
        check("t2_a", alu_a, 32'h1234);
        check("t2_b", alu_b, 1);
        check("t2_dest", alu_dest, 4);
        tick();

        // Allocation bypass from a same-cycle broadcast
        set_alloc(ALU_AND, 4, 0, NL, 3, 5);
        cdb_index = 4; cdb_result = 9;
        tick(); dec_valid = 0; cdb_index = NL;
        tick();
        check("t3_valid", alu_valid, 1);
        check("t3_a", alu_a, 9);
        check("t3_b", alu_b, 3);
        tick();

        // Fill, ignore extra request, then drain in allocation order
        alu_ready = 0;
        for (int k = 0; k < 4; k++) begin
            set_alloc(ALU_OR, 6, 0, NL, 32'(16 + k), TW'(8 + k));
            tick();
        end
        dec_valid = 0;
        check("t4_full", rs_full, 1);
        set_alloc(ALU_XOR, NL, 1, NL, 2, 12);
        tick(); dec_valid = 0;
        check("t4_still_full", rs_full, 1);
        check("t4_no_issue", alu_valid, 0);
        cdb_index = 6; cdb_result = 32'h66; alu_ready = 1;
        tick(); cdb_index = NL;
        check("t4_cap", alu_valid, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t4_valid", alu_valid, 1);
            check("t4_dest", alu_dest, 8 + k);
            check("t4_a", alu_a, 32'h66);
            check("t4_b", alu_b, 16 + k);
            if (k == 0) check("t4_full_drop", rs_full, 0);
        end
        tick();
        check("t4_empty", alu_valid, 0);

        // Hold under back-pressure, then flush
        alu_ready = 0;
        set_alloc(ALU_ADD, NL, 1, NL, 10, 13);
        tick();
        set_alloc(ALU_ADD, NL, 2, NL, 20, 14);
        tick(); dec_valid = 0;
        check("t5_valid", alu_valid, 1);
        check("t5_dest", alu_dest, 13);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t5_hold_valid", alu_valid, 1);
            check("t5_hold_dest", alu_dest, 13);
            check("t5_hold_a", alu_a, 1);
        end
        flush = 1;
        tick(); flush = 0;
        check("t5_flush_valid", alu_valid, 0);
        check("t5_flush_full", rs_full, 0);
        alu_ready = 1;
        tick();
        check("t5_flushed_entry", alu_valid, 0);

        // Asynchronous reset mid-burst
        set_alloc(ALU_SLL, NL, 3, NL, 4, 1);
        tick();
        set_alloc(ALU_SLL, NL, 5, NL, 6, 2);
        tick();
        set_alloc(ALU_SLL, NL, 7, NL, 8, 3);
        tick(); dec_valid = 0;
        check("t6_burst_valid", alu_valid, 1);
        check("t6_burst_dest", alu_dest, 2);
        #2 rst = 1;
        #1;
        check("t6_rst_valid", alu_valid, 0);
        check("t6_rst_a", alu_a, 0);
        check("t6_rst_b", alu_b, 0);
        check("t6_rst_op", alu_op, 0);
        check("t6_rst_dest", alu_dest, NL);
        check("t6_rst_full", rs_full, 0);
        tick(); tick();
        rst = 0;
        tick(); tick();
        check("t6_no_issue", alu_valid, 0);
        set_alloc(ALU_ADD, NL, 100, NL, 200, 7);
        tick(); dec_valid = 0;
        tick();
        check("t6_new_valid", alu_valid, 1);
        check("t6_new_a", alu_a, 100);
        check("t6_new_dest", alu_dest, 7);
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_rs.md
# alu_rs

ALU reservation station: the consuming end of the common data bus. Accepts decoded ALU instructions whose operands are either values or ROB tags, snoops the CDB broadcast (index/result) to capture pending operands, and issues the oldest ready entry to the ALU over a valid/ready output register. Sits between the decoder/issue stage and the ALU, whose result returns through the CDB.

## Interface
- ENTRIES, 4: number of station entries (power of two, ≥2).
- DATA_W, `Data_Width (32): operand/result width.
- TAG_W, `Reg_Lock_Width: ROB tag width; value `Reg_No_Lock means "operand valid / no broadcast".
- OP_W, 5: ALU opcode width.

- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous mispredict flush.
- dec_valid  in  1  allocation request.
- dec_op  in  OP_W  opcode.
- dec_tag_a / dec_tag_b  in  TAG_W  source tags (`Reg_No_Lock = value valid).
- dec_val_a / dec_val_b  in  DATA_W  source values (used when tag is `Reg_No_Lock).
- dec_dest  in  TAG_W  destination ROB tag.
- rs_full  out  1  all entries busy; decoder must not assert dec_valid.
- cdb_index  in  TAG_W  broadcast tag; `Reg_No_Lock = idle.
- cdb_result  in  DATA_W  broadcast value.
- alu_valid  out  1  issued instruction present.
- alu_ready  in  1  ALU accepts this cycle.
- alu_op  out  OP_W; alu_a, alu_b  out  DATA_W; alu_dest  out  TAG_W.

## Operation
- Entry state: busy, op, qa, va, qb, vb, dest, age (log2 ENTRIES bits).
- Allocate when dec_valid && !rs_full: lowest-index free entry. dec_valid while rs_full is ignored.
- Allocation bypass: if dec_tag_x == cdb_index != `Reg_No_Lock in the same cycle, entry stores qx=`Reg_No_Lock, vx=cdb_result.
- Wake-up: every busy entry with qx == cdb_index != `Reg_No_Lock sets qx=`Reg_No_Lock, vx=cdb_result. Both operands may wake on one broadcast.
- Ready: busy && qa==`Reg_No_Lock && qb==`Reg_No_Lock, evaluated on registered state (no same-cycle CDB→issue path).
- Select: ready entry with smallest age; age is unique among busy entries, so no tie.
- Output register loads selected entry and frees it when (!alu_valid || alu_ready) and a ready entry exists; if none, alu_valid clears on alu_ready. Held stable while alu_valid && !alu_ready.
- Age: on issue of age k, busy entries with age>k decrement. New entry's age = number of busy entries after this cycle's issue removal.
- rs_full = all busy (from registers). A slot freed by issue is usable next cycle only.
- flush: clears all busy, alu_valid, ages; dominates allocation/issue same cycle.

## Timing
- Reset (async): all busy=0, rs_full=0, alu_valid=0, alu_op=0, alu_a=0, alu_b=0, alu_dest=`Reg_No_Lock.
- Allocate with ready operands at edge N → alu_valid high after edge N+1 (min 2-edge latency).
- CDB capture at edge N → entry eligible for issue in cycle after N, alu_valid after edge N+1.
- Back-to-back issue: one instruction per cycle while alu_ready high.
- Reset mid-operation discards all entries and any pending output.

## Structure
- Shared defines: `Data_Width, `Reg_Lock_Width, `Reg_No_Lock, `ROB_Entry_Width, ALU opcode constants.
- Optional sub-module rs_select: ready vector + ages → one-hot oldest-ready grant and any-ready flag.

## Test plan
- Reset then dec_valid, op=ADD, tags `Reg_No_Lock, a=5, b=7, dest=3 → alu_valid after 2 edges, alu_a=5, alu_b=7, alu_dest=3.
- Allocate qa=2; later cdb_index=2, cdb_result=0x1234 → alu_a=0x1234 issued one cycle after broadcast.
- Allocate with qa=4 in the same cycle as cdb_index=4, result=9 → entry captures 9, issues as if ready.
- Fill 4 entries, all waiting on tag 6, alu_ready=0 → rs_full=1, extra dec_valid ignored; broadcast tag 6, alu_ready=1 → issue in allocation order, one per cycle, rs_full drops after first issue.
- alu_ready=0 with alu_valid=1 for 3 cycles → outputs held constant; flush → alu_valid=0, rs_full=0 next cycle.
- Assert rst asynchronously mid-burst → outputs at reset values immediately, no issue after release until new allocation.
